sprite_blit_ctrl: RTL and testbench
===================================

// Module: sprite_blit_ctrl
// PURPOSE
//  Copies one 32x32 sprite (bike up/down/left/right, red/blue) from the selected sprite RAM into the
//  640x480 frame RAM at a commanded (x,y). Transparent pixels and off-screen pixels are skipped.
//  Sits between game logic (command side) and the frame/sprite RAMs; owns their read/write ports.
//  Frame-RAM writes use a valid/grant handshake so the frame-port arbiter can stall it.
// PARAMETERS
//  SPR_W      32     sprite width, pixels
//  SPR_H      32     sprite height, pixels
//  FB_W       640    frame width, pixels
//  FB_H       480    frame height, pixels
//  TRANSP_KEY 8'h00  sprite pixel value never written to frame RAM
// PORTS
//  Clk        in   1   system clock; all state on rising edge
//  Reset_n    in   1   asynchronous, active-low reset
//  cmd_valid  in   1   command offered
//  cmd_ready  out  1   command accepted on edge where cmd_valid&&cmd_ready
//  cmd_x      in   10  sprite left column in frame (0..1023; >=FB_W fully clipped)
//  cmd_y      in   9   sprite top row in frame (0..511; >=FB_H fully clipped)
//  cmd_sel    in   3   {red(1)/blue(0), dir[1:0]: 0=up 1=down 2=left 3=right}
//  spr_sel    out  3   selects sprite RAM output mux; equals latched cmd_sel
//  spr_addr   out  20  sprite RAM read_address, row*SPR_W+col
//  spr_data   in   8   sprite RAM data_Out (registered RAM, 1-cycle read latency)
//  fb_we      out  1   frame write valid
//  fb_grant   in   1   frame write ready; write retires on edge where fb_we&&fb_grant
//  fb_addr    out  20  frame RAM write_address, (y+row)*FB_W+(x+col)
//  fb_data    out  8   frame RAM data_In
//  busy       out  1   high in any state but IDLE
//  done       out  1   one-cycle pulse when a blit completes
// BEHAVIOUR
//  Reset (async, any state, mid-blit included): state=IDLE, cmd_ready=1, busy=0, done=0, fb_we=0,
//   fb_addr=0, fb_data=0, spr_addr=0, spr_sel=0, skid empty; partial blit abandoned, no resume.
//  States: IDLE -> RUN on cmd accept (cmd_x/y/sel latched); RUN -> DRAIN after last read issued;
//   DRAIN -> DONE when pipeline and skid empty and no fb_we pending; DONE -> IDLE next cycle (done=1 there).
//  cmd_ready=1 only in IDLE; cmd_valid in other states ignored, not queued.
//  Pipeline: S0 issues spr_addr (pixel index 0..SPR_W*SPR_H-1, row-major, one per cycle);
//   S1 one cycle later sees spr_data for that index with its registered row/col;
//   S1 computes clip/transparency and registers fb_we/fb_addr/fb_data.
//  Latency: accept at edge E0; spr_addr=0 driven after E0; first possible fb_we=1 after E0+2.
//  Write emitted only if spr_data!=TRANSP_KEY and x+col<FB_W and y+row<FB_H (11-bit/10-bit sums,
//   no wrap); skipped pixels consume a slot but drive fb_we=0.
//  fb_addr computed at 20 bits from unclipped-safe values only; max 307199.
//  Backpressure: fb_we/fb_addr/fb_data hold stable while fb_grant=0. S0 stops issuing; the one
//   pixel already in flight is captured in a 1-entry skid register (data+row+col) so RAM
//   re-read is not needed. Order of writes strictly row-major; no pixel lost or duplicated.
//  fb_grant ignored when fb_we=0. spr_addr holds last value once reads complete.
//  Fully clipped command still walks all pixels, writes nothing, pulses done.
//  Throughput with fb_grant=1: one pixel per cycle; blit of 1024 px completes in 1024+4 cycles max.
// TESTING
//  1 sel=3'b000,(100,50), sprite all 8'h11, grant=1 -> 1024 writes, first fb_addr 32100,
//    last 51971, all data 8'h11, single done pulse, cmd_ready=1 next cycle.
//  2 sprite checkerboard 8'h00/8'h2A, (0,0) -> exactly 512 writes, only 8'h2A, addrs match pattern.
//  3 (620,460) -> 400 writes, none with column>=640 or row>=480; (700,10) -> 0 writes, done pulses.
//  4 test 1 with fb_grant random 50% -> identical 1024-write sequence in order, fb_* stable while stalled.
//  5 Reset_n low after 300 writes -> fb_we=0, busy=0 immediately; after release new blit at (0,0)
//    correct from pixel 0.
//  6 cmd_valid held high with second command during blit -> not accepted until IDLE; second blit
//    starts after done, both results correct.

Source files
------------

// File: rtl/sprite_blit_ctrl.sv
// Sprite blitter: copies one 32x32 sprite into the 640x480 frame RAM at (x,y).
// Transparent and off-screen pixels are skipped. Frame writes use a valid/grant handshake.
module sprite_blit_ctrl #(
   parameter int unsigned SPR_W      = 32,
   parameter int unsigned SPR_H      = 32,
   parameter int unsigned FB_W       = 640,
   parameter int unsigned FB_H       = 480,
   parameter logic [7:0]  TRANSP_KEY = 8'h00
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [9:0]  cmd_x,
   input  logic [8:0]  cmd_y,
   input  logic [2:0]  cmd_sel,
   output logic [2:0]  spr_sel,
   output logic [19:0] spr_addr,
   input  logic [7:0]  spr_data,
   output logic        fb_we,
   input  logic        fb_grant,
   output logic [19:0] fb_addr,
   output logic [7:0]  fb_data,
   output logic        busy,
   output logic        done
);

   localparam int unsigned NPIX  = SPR_W * SPR_H;
   localparam int unsigned IDX_W = $clog2(NPIX);
   localparam int unsigned COL_W = $clog2(SPR_W);
   localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'(NPIX - 2);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [9:0]       cmd_x_q, cmd_x_d;
   logic [8:0]       cmd_y_q, cmd_y_d;
   logic [2:0]       spr_sel_q, spr_sel_d;
   logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
   logic             a_vld_q, a_vld_d;
   logic             s1_vld_q, s1_vld_d;
   logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
   logic             skid_vld_q, skid_vld_d;
   logic [7:0]       skid_data_q, skid_data_d;
   logic [IDX_W-1:0] skid_idx_q, skid_idx_d;
   logic             fb_we_q, fb_we_d;
   logic [19:0]      fb_addr_q, fb_addr_d;
   logic [7:0]       fb_data_q, fb_data_d;

   logic             stall, issue, src_vld, wr_ok;
   logic [7:0]       src_data;
   logic [IDX_W-1:0] src_idx;
   logic [10:0]      px;
   logic [9:0]       py;

   always_comb begin
      // NOTE: every variable gets a default before any branch, so no latch can be inferred.
      stall    = fb_we_q && !fb_grant;
      // Reads advance only when nothing is parked, which keeps at most one pixel needing the skid.
      issue    = (state_q == ST_RUN) && !stall && !skid_vld_q;
      src_vld  = skid_vld_q || s1_vld_q;
      src_data = skid_vld_q ? skid_data_q : spr_data;
      src_idx  = skid_vld_q ? skid_idx_q : s1_idx_q;
      px       = 11'(cmd_x_q) + 11'(src_idx[COL_W-1:0]);
      py       = 10'(cmd_y_q) + 10'(src_idx[IDX_W-1:COL_W]);
      wr_ok    = src_vld && (src_data != TRANSP_KEY) && (px < 11'(FB_W)) && (py < 10'(FB_H));

      state_d   = state_q;
      cmd_x_d   = cmd_x_q;
      cmd_y_d   = cmd_y_q;
      spr_sel_d = spr_sel_q;
      rd_idx_d  = rd_idx_q;
      a_vld_d   = 1'b0;
      case (state_q)
         ST_IDLE: if (cmd_valid) begin
            state_d   = ST_RUN;
            cmd_x_d   = cmd_x;
            cmd_y_d   = cmd_y;
            spr_sel_d = cmd_sel;
            rd_idx_d  = '0;
            a_vld_d   = 1'b1;
         end
         ST_RUN: if (issue) begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
            a_vld_d  = 1'b1;
            if (rd_idx_q == PENULT_IDX) state_d = ST_DRAIN;
         end
         ST_DRAIN: if (!a_vld_q && !s1_vld_q && !skid_vld_q && !fb_we_q) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // S1 only holds when stalled with the skid full; the read address is then unchanged,
      // so spr_data keeps presenting the held pixel.
      s1_vld_d = a_vld_q || (s1_vld_q && stall && skid_vld_q);
      s1_idx_d = a_vld_q ? rd_idx_q : s1_idx_q;

      skid_vld_d  = stall ? (skid_vld_q || s1_vld_q) : (skid_vld_q && s1_vld_q);
      skid_data_d = skid_data_q;
      skid_idx_d  = skid_idx_q;
      if (s1_vld_q && (stall != skid_vld_q)) begin
         skid_data_d = spr_data;
         skid_idx_d  = s1_idx_q;
      end

      fb_we_d   = fb_we_q;
      fb_addr_d = fb_addr_q;
      fb_data_d = fb_data_q;
      if (!stall) begin
         fb_we_d = wr_ok;
         if (wr_ok) begin
            fb_addr_d = 20'(py) * 20'(FB_W) + 20'(px);
            fb_data_d = src_data;
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= ST_IDLE;
         cmd_x_q     <= '0;
         cmd_y_q     <= '0;
         spr_sel_q   <= '0;
         rd_idx_q    <= '0;
         a_vld_q     <= 1'b0;
         s1_vld_q    <= 1'b0;
         s1_idx_q    <= '0;
         skid_vld_q  <= 1'b0;
         skid_data_q <= '0;
         skid_idx_q  <= '0;
         fb_we_q     <= 1'b0;
         fb_addr_q   <= '0;
         fb_data_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q     <= state_d;
         cmd_x_q     <= cmd_x_d;
         cmd_y_q     <= cmd_y_d;
         spr_sel_q   <= spr_sel_d;
         rd_idx_q    <= rd_idx_d;
         a_vld_q     <= a_vld_d;
         s1_vld_q    <= s1_vld_d;
         s1_idx_q    <= s1_idx_d;
         skid_vld_q  <= skid_vld_d;
         skid_data_q <= skid_data_d;
         skid_idx_q  <= skid_idx_d;
         fb_we_q     <= fb_we_d;
         fb_addr_q   <= fb_addr_d;
         fb_data_q   <= fb_data_d;
      end
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign spr_sel   = spr_sel_q;
   assign spr_addr  = 20'(rd_idx_q);
   assign fb_we     = fb_we_q;
   assign fb_addr   = fb_addr_q;
   assign fb_data   = fb_data_q;

endmodule

// File: tb/tb_sprite_blit_ctrl.sv
// Directed bench for sprite_blit_ctrl: registered sprite RAM model, frame-write capture,
// optional random grant, and a reference list of expected writes per blit.
module tb_sprite_blit_ctrl;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [9:0]  cmd_x;
   logic [8:0]  cmd_y;
   logic [2:0]  cmd_sel;
   logic [2:0]  spr_sel;
   logic [19:0] spr_addr;
   logic [7:0]  spr_data;
   logic        fb_we;
   logic        fb_grant = 1'b1;
   logic [19:0] fb_addr;
   logic [7:0]  fb_data;
   logic        busy;
   logic        done;

   always #5 Clk = ~Clk;

   sprite_blit_ctrl dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_sel(cmd_sel),
      .spr_sel(spr_sel), .spr_addr(spr_addr), .spr_data(spr_data),
      .fb_we(fb_we), .fb_grant(fb_grant), .fb_addr(fb_addr), .fb_data(fb_data),
      .busy(busy), .done(done)
   );

   logic [7:0] spr_mem [0:1023];
   always @(posedge Clk) spr_data <= spr_mem[spr_addr[9:0]];

   int total = 0;
   int bad   = 0;
   logic [19:0] wr_addr  [$];
   logic [7:0]  wr_data  [$];
   logic [19:0] exp_addr [$];
   logic [7:0]  exp_data [$];
   bit          grant_rand = 1'b0;
   bit          stall_prev = 1'b0;
   logic [19:0] p_addr;
   logic [7:0]  p_data;
   int          stab_err  = 0;
   int          stall_cnt = 0;
   int          done_cnt  = 0;

   // Grant is chosen at the falling edge; a write retires at the next rising edge if fb_we && fb_grant.
   always @(negedge Clk) begin
      fb_grant = grant_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (stall_prev && (fb_we !== 1'b1 || fb_addr !== p_addr || fb_data !== p_data)) stab_err++;
      stall_prev = fb_we && !fb_grant;
      p_addr = fb_addr;
      p_data = fb_data;
      if (stall_prev) stall_cnt++;
      if (fb_we && fb_grant) begin
         wr_addr.push_back(fb_addr);
         wr_data.push_back(fb_data);
      end
      if (done) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic fill(input int mode);
      for (int i = 0; i < 1024; i++) begin
         case (mode)
            0:       spr_mem[i] = 8'h11;
            1:       spr_mem[i] = (((i / 32) + (i % 32)) % 2 == 1) ? 8'h2A : 8'h00;
            default: spr_mem[i] = 8'((i % 255) + 1);
         endcase
      end
   endtask

   task automatic clear_all();
      wr_addr.delete();
      wr_data.delete();
      exp_addr.delete();
      exp_data.delete();
      done_cnt = 0;
   endtask

   task automatic build_exp(input int x, input int y);
      for (int i = 0; i < 1024; i++) begin
         int px;
         int py;
         px = x + (i % 32);
         py = y + (i / 32);
         if (spr_mem[i] != 8'h00 && px < 640 && py < 480) begin
            exp_addr.push_back(20'(py * 640 + px));
            exp_data.push_back(spr_mem[i]);
         end
      end
   endtask

   function automatic logic [31:0] wr_at(input int i);
      if (i >= 0 && i < wr_addr.size()) return 32'(wr_addr[i]);
      return 'x;
   endfunction

   task automatic compare_writes(input string tag);
      int errs;
      errs = 0;
      check({tag, "_count_vs_model"}, wr_addr.size(), exp_addr.size());
      for (int i = 0; i < exp_addr.size(); i++)
         if (i >= wr_addr.size() || wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) errs++;
      check({tag, "_seq_err"}, errs, 0);
   endtask

   task automatic start_cmd(input logic [9:0] x, input logic [8:0] y, input logic [2:0] sel,
                            input bit hold);
      int n;
      n = 0;
      cmd_valid = 1'b1;
      cmd_x = x;
      cmd_y = y;
      cmd_sel = sel;
      while (!cmd_ready && n < 3000) begin
         tick();
         n++;
      end
      check("accept_ready", cmd_ready, 1);
      tick();
      if (!hold) cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int limit, output int n);
      n = 0;
      while (!done && n < limit) begin
         tick();
         n++;
      end
      check(tag, done, 1);
   endtask

   initial begin
      int n;
      int rdy_seen;
      Reset_n = 1'b0;
      cmd_valid = 1'b0;
      cmd_x = '0;
      cmd_y = '0;
      cmd_sel = '0;
      fill(0);
      #12;
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_fb_we", fb_we, 0);
      check("rst_fb_addr", fb_addr, 0);
      check("rst_fb_data", fb_data, 0);
      check("rst_spr_addr", spr_addr, 0);
      check("rst_spr_sel", spr_sel, 0);
      tick();
      Reset_n = 1'b1;
      tick();

      // Test 1: uniform sprite at (100,50), grant always high
      fill(0);
      clear_all();
      build_exp(100, 50);
      start_cmd(10'd100, 9'd50, 3'b000, 1'b0);
      check("t1_e0_fb_we", fb_we, 0);
      check("t1_e0_spr_addr", spr_addr, 0);
      check("t1_e0_busy", busy, 1);
      check("t1_e0_cmd_ready", cmd_ready, 0);
      tick();
      check("t1_e1_fb_we", fb_we, 0);
      check("t1_e1_spr_addr", spr_addr, 1);
      tick();
      check("t1_e2_fb_we", fb_we, 1);
      check("t1_e2_fb_addr", fb_addr, 32100);
      check("t1_e2_fb_data", fb_data, 8'h11);
      wait_done("t1_done", 1100, n);
      check("t1_cycles_le_1028", (n + 2 <= 1028), 1);
      tick();
      check("t1_ready_after", cmd_ready, 1);
      check("t1_busy_after", busy, 0);
      check("t1_done_one_cycle", done, 0);
      check("t1_done_pulses", done_cnt, 1);
      check("t1_writes", wr_addr.size(), 1024);
      check("t1_first_addr", wr_at(0), 32100);
      check("t1_last_addr", wr_at(1023), 51971);
      compare_writes("t1");

      // Test 2: checkerboard at (0,0)
      fill(1);
      clear_all();
      build_exp(0, 0);
      start_cmd(10'd0, 9'd0, 3'b110, 1'b0);
      check("t2_spr_sel", spr_sel, 3'b110);
      wait_done("t2_done", 1100, n);
      tick();
      check("t2_writes", wr_addr.size(), 512);
      check("t2_first_addr", wr_at(0), 1);
      check("t2_last_addr", wr_at(511), 19870);
      compare_writes("t2");

      // Test 3: partial clip at (620,460), then full clip at (700,10)
      fill(0);
      clear_all();
      build_exp(620, 460);
      start_cmd(10'd620, 9'd460, 3'b111, 1'b0);
      wait_done("t3a_done", 1100, n);
      tick();
      check("t3a_writes", wr_addr.size(), 400);
      check("t3a_first_addr", wr_at(0), 295020);
      check("t3a_last_addr", wr_at(399), 307199);
      compare_writes("t3a");
      clear_all();
      start_cmd(10'd700, 9'd10, 3'b000, 1'b0);
      wait_done("t3b_done", 1100, n);
      tick();
      check("t3b_writes", wr_addr.size(), 0);
      check("t3b_done_pulses", done_cnt, 1);

      // Test 4: random 50% grant, distinct pixel values to expose loss, duplication or reordering
      fill(2);
      clear_all();
      build_exp(100, 50);
      stab_err = 0;
      stall_cnt = 0;
      grant_rand = 1'b1;
      start_cmd(10'd100, 9'd50, 3'b000, 1'b0);
      wait_done("t4_done", 8000, n);
      tick();
      grant_rand = 1'b0;
      check("t4_writes", wr_addr.size(), 1024);
      check("t4_first_addr", wr_at(0), 32100);
      compare_writes("t4");
      check("t4_stable_while_stalled_err", stab_err, 0);
      check("t4_stalls_seen", (stall_cnt > 0), 1);

      // Test 5: reset after 300 writes, then a fresh blit at (0,0)
      fill(0);
      clear_all();
      start_cmd(10'd0, 9'd0, 3'b000, 1'b0);
      n = 0;
      while (wr_addr.size() < 300 && n < 2000) begin
         tick();
         n++;
      end
      check("t5_reached_300", (wr_addr.size() >= 300), 1);
      Reset_n = 1'b0;
      #1;
      check("t5_rst_fb_we", fb_we, 0);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_cmd_ready", cmd_ready, 1);
      check("t5_rst_spr_addr", spr_addr, 0);
      tick();
      Reset_n = 1'b1;
      tick();
      fill(2);
      clear_all();
      build_exp(0, 0);
      start_cmd(10'd0, 9'd0, 3'b011, 1'b0);
      wait_done("t5_done", 1100, n);
      tick();
      check("t5_writes", wr_addr.size(), 1024);
      check("t5_first_addr", wr_at(0), 0);
      compare_writes("t5");

      // Test 6: second command held during the first blit is taken only after done
      fill(2);
      clear_all();
      build_exp(0, 0);
      build_exp(200, 100);
      start_cmd(10'd0, 9'd0, 3'b001, 1'b1);
      cmd_x = 10'd200;
      cmd_y = 9'd100;
      cmd_sel = 3'b010;
      n = 0;
      rdy_seen = 0;
      while (!done && n < 1200) begin
         if (cmd_ready) rdy_seen++;
         tick();
         n++;
      end
      check("t6_first_done", done, 1);
      check("t6_ready_during_blit", rdy_seen, 0);
      check("t6_sel_kept", spr_sel, 3'b001);
      tick();
      check("t6_ready_in_idle", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      check("t6_second_busy", busy, 1);
      check("t6_second_sel", spr_sel, 3'b010);
      wait_done("t6_second_done", 1100, n);
      tick();
      check("t6_writes", wr_addr.size(), 2048);
      check("t6_second_first_addr", wr_at(1024), 64200);
      check("t6_done_pulses", done_cnt, 2);
      compare_writes("t6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
